store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Small in-order write buffer between the MEM-stage store aligner and the data memory write port.
- Accepts stores whose data is already lane-aligned, together with their byte-enable mask. Drains them to memory over a req/gnt handshake.
- Optionally merges consecutive stores to the same word.
- Reports load/store hazards so the pipeline can stall loads that overlap pending stores.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_W, 32, byte address width.
- MERGE_EN, 1, 1 enables tail write-merging; 0 disables it.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- st_valid  in  1  store request from MEM stage.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  ADDR_W  store byte address; bits [1:0] ignored.
- st_data  in  32  lane-aligned store data.
- st_mask  in  4  byte enables; 4'b0000 is legal and is dropped.
- mem_req  out  1  head entry presented to memory.
- mem_gnt  in  1  memory accepts the head entry this cycle.
- mem_addr  out  ADDR_W  head word address, bits [1:0] forced to 0.
- mem_wdata  out  32  head data.
- mem_we  out  4  head byte enables.
- ld_addr  in  ADDR_W  address of the load in MEM.
- ld_mask  in  4  bytes the load reads.
- ld_hazard  out  1  load overlaps a pending entry.
- empty  out  1  no pending entries.
- count  out  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset
  - When rst_n=0 at a rising edge: head/tail pointers=0, count=0, all entry valid bits=0.
  - While rst_n=0: st_ready=0, mem_req=0, ld_hazard=0, empty=1.
  - Reset mid-drain discards all entries; no completion is reported for them.
- Flow control
  - st_ready = rst_n && (count < DEPTH).
  - Accept = st_valid && st_ready. An accept with st_mask=0 changes nothing.
- Enqueue
  - On accept, the entry {st_addr[ADDR_W-1:2], st_data, st_mask} is written at tail. Tail increments mod DEPTH; count+1.
- Merge (MERGE_EN=1)
  - Condition: accept, count>=2, and the tail-1 entry word address equals st_addr word address.
  - Instead of enqueueing, update the tail-1 entry: for each byte i with st_mask[i]=1, data byte i takes st_data byte i; mask |= st_mask. Count and tail are unchanged.
  - The head is never merged into, because it may be under handshake.
- Drain
  - mem_req = !empty. mem_addr, mem_wdata and mem_we come directly from registered head storage, with no added latency.
  - The request and its payload must stay stable until mem_gnt. On mem_req && mem_gnt: head increments mod DEPTH; count-1.
- Latency
  - A store accepted at edge N appears on mem_req in cycle N+1 if the buffer was empty. Throughput is 1 store/cycle in and 1/cycle out.
- Simultaneous accept and grant
  - Both take effect in the same edge; count is unchanged.
  - When full, st_ready=0 even if mem_gnt=1; there is no pass-through.
  - Merge eligibility uses count before the edge.
- Hazard
  - ld_hazard = OR over valid entries of (entry word addr == ld_addr word addr && |(entry mask & ld_mask)).
  - It is combinational from registered entries only. A store being accepted in the same cycle is not checked; the pipeline orders the load after it.
- Pointer wrap
  - Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer equality.

Decomposition:
- Shared package kira_mem_pkg:
  - sb_entry_t struct {word_addr, data[31:0], mask[3:0]}.
  - Typedef byte_en_t = logic[3:0].
  - Constant WORD_OFF_W = 2.
- Sub-module sb_match: one entry vs load address/mask compare, producing a single hit bit. It is instantiated DEPTH times and OR-reduced in store_buffer.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1 -> st_ready=1, mem_req=0, empty=1, count=0.
2. Single store, st_addr=0x100, st_data=0x0000AB00, st_mask=4'b0010, mem_gnt=1 -> next cycle mem_req=1, mem_addr=0x100, mem_we=4'b0010, mem_wdata=0x0000AB00; following cycle empty=1.
3. Fill with mem_gnt=0, DEPTH+1 stores at distinct words -> st_ready=0 after 4 accepts, count=4, fifth store held. Raise mem_gnt -> drains in order 0x000,0x004,0x008,0x00C, then the fifth.
4. Merge with mem_gnt=0: stores 0x200/mask 4'b0001/data 0x11, 0x300/4'b0001/0x22, 0x300/4'b1000/0x33000000 -> count=2, second entry mem_we=4'b1001, data 0x33000022.
5. Hazard with pending 0x300/mask 4'b1001: ld_addr=0x302, ld_mask=4'b0100 -> ld_hazard=0. ld_mask=4'b1000 -> ld_hazard=1. ld_addr=0x304 -> 0.
6. Reset mid-drain: 3 entries pending, mem_gnt=0, rst_n=0 for one edge -> count=0, mem_req=0; the old head never reappears after reset.

Source files
------------

// File: rtl/kira_mem_pkg.sv
// Shared memory-side types: store buffer entry layout and byte-lane helpers.
package kira_mem_pkg;

    localparam int WORD_OFF_W = 2;
    localparam int SB_WADDR_W = 30;

    typedef logic [3:0] byte_en_t;

    typedef struct packed {
        logic [SB_WADDR_W-1:0] word_addr;
        logic [31:0]           data;
        byte_en_t              mask;
    } sb_entry_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_d,
        input logic [31:0] new_d,
        input byte_en_t    m
    );
        logic [31:0] r;
        r = old_d;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = new_d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_match.sv
// One store buffer entry checked against the load in MEM.
module sb_match
    import kira_mem_pkg::*;
(
    input  logic                  valid,
    input  sb_entry_t             entry,
    input  logic [SB_WADDR_W-1:0] ld_word,
    input  byte_en_t              ld_mask,
    output logic                  hit
);

    assign hit = valid
              && (entry.word_addr == ld_word)
              && |(entry.mask & ld_mask);

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage aligner and the data memory
// write port, with tail write-merging and load hazard detection.
module store_buffer
    import kira_mem_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter bit MERGE_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_mask,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_we,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [3:0]               ld_mask,
    output logic                     ld_hazard,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WA = ADDR_W - WORD_OFF_W;

    sb_entry_t             ent [DEPTH];
    logic [DEPTH-1:0]      vld;
    logic [DEPTH-1:0]      hit;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         tailm1;
    logic [CW-1:0]         cnt;
    logic [SB_WADDR_W-1:0] st_word;
    logic [SB_WADDR_W-1:0] ld_word;
    logic                  accept;
    logic                  merge;
    logic                  push;
    logic                  pop;
    logic                  unused_off;

    // Entries hold word addresses only; the byte offset bits are dropped.
    always_comb begin
        st_word = '0;
        ld_word = '0;
        st_word[WA-1:0] = st_addr[ADDR_W-1:WORD_OFF_W];
        ld_word[WA-1:0] = ld_addr[ADDR_W-1:WORD_OFF_W];
    end

    assign unused_off = ^{st_addr[WORD_OFF_W-1:0], ld_addr[WORD_OFF_W-1:0]};

    assign tailm1   = tail - 1'b1;
    assign st_ready = rst_n && (cnt < CW'(DEPTH));
    assign mem_req  = rst_n && (cnt != '0);
    assign empty    = !rst_n || (cnt == '0);
    assign count    = cnt;
    assign accept   = st_valid && st_ready && (st_mask != 4'b0000);
    assign pop      = mem_req && mem_gnt;

    // Head is excluded from merging since it may be mid-handshake.
    assign merge = MERGE_EN
                && accept
                && (cnt >= CW'(2))
                && (ent[tailm1].word_addr == st_word);
    assign push  = accept && !merge;

    assign mem_addr  = {ent[head].word_addr[WA-1:0], {WORD_OFF_W{1'b0}}};
    assign mem_wdata = ent[head].data;
    assign mem_we    = ent[head].mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent[tail] <= '{word_addr: st_word, data: st_data, mask: st_mask};
        end
        if (merge) begin
            ent[tailm1].data <= merge_bytes(ent[tailm1].data, st_data, st_mask);
            ent[tailm1].mask <= ent[tailm1].mask | st_mask;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        sb_match u_match (
            .valid   (vld[i]),
            .entry   (ent[i]),
            .ld_word (ld_word),
            .ld_mask (ld_mask),
            .hit     (hit[i])
        );
    end

    assign ld_hazard = rst_n && |hit;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue model plus directed vectors.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] ld_addr;
    logic [3:0]  ld_mask;
    logic        ld_hazard;
    logic        empty;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  m;
    } ment_t;

    ment_t q[$];

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .MERGE_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_mask   (st_mask),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .ld_addr   (ld_addr),
        .ld_mask   (ld_mask),
        .ld_hazard (ld_hazard),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mask  = m;
        tick();
        st_valid = 1'b0;
    endtask

    // Model: a FIFO of pending words; merge folds into the last one.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit    rdy;
            bit    gnt;
            ment_t e;
            rdy = q.size() < DEPTH;
            gnt = (q.size() != 0) && mem_gnt;
            if (st_valid && rdy && st_mask != 4'b0000) begin
                if (q.size() >= 2 && q[q.size()-1].w == st_addr[31:2]) begin
                    e = q[q.size()-1];
                    for (int b = 0; b < 4; b++)
                        if (st_mask[b]) e.d[8*b +: 8] = st_data[8*b +: 8];
                    e.m = e.m | st_mask;
                    q[q.size()-1] = e;
                end else begin
                    e.w = st_addr[31:2];
                    e.d = st_data;
                    e.m = st_mask;
                    q.push_back(e);
                end
            end
            if (gnt) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit hz;
            hz = 1'b0;
            if (rst_n) begin
                foreach (q[i])
                    if (q[i].w == ld_addr[31:2] && (q[i].m & ld_mask) != 0)
                        hz = 1'b1;
                chk("cyc_count", 32'(count), 32'(q.size()));
            end
            chk("cyc_ready", 32'(st_ready), 32'(rst_n && q.size() < DEPTH));
            chk("cyc_req", 32'(mem_req), 32'(rst_n && q.size() != 0));
            chk("cyc_empty", 32'(empty), 32'(!rst_n || q.size() == 0));
            chk("cyc_hazard", 32'(ld_hazard), 32'(hz));
            if (rst_n && q.size() != 0) begin
                chk("cyc_addr", mem_addr, {q[0].w, 2'b00});
                chk("cyc_wdata", mem_wdata, q[0].d);
                chk("cyc_we", 32'(mem_we), 32'(q[0].m));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mask  = '0;
        mem_gnt  = 1'b0;
        ld_addr  = '0;
        ld_mask  = '0;

        // 1: reset then idle
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // 2: single store drains next cycle
        tick();
        mem_gnt = 1'b1;
        store(32'h100, 32'h0000AB00, 4'b0010);
        @(negedge clk);
        chk("one_req", 32'(mem_req), 32'd1);
        chk("one_addr", mem_addr, 32'h100);
        chk("one_we", 32'(mem_we), 32'h2);
        chk("one_wdata", mem_wdata, 32'h0000AB00);
        tick();
        @(negedge clk);
        chk("one_empty", 32'(empty), 32'd1);

        // 3: fill, hold fifth, then drain in order
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'(i + 1), 4'hF);
        st_valid = 1'b1;
        st_addr  = 32'h10;
        st_data  = 32'h55;
        st_mask  = 4'hF;
        tick();
        @(negedge clk);
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        tick();
        mem_gnt = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("drain_addr", mem_addr, 32'(j * 4));
            tick();
            if (j == 1) st_valid = 1'b0;
        end
        @(negedge clk);
        chk("drain_empty", 32'(empty), 32'd1);

        // 4: merge into tail-1
        tick();
        mem_gnt = 1'b0;
        store(32'h200, 32'h11, 4'b0001);
        store(32'h300, 32'h22, 4'b0001);
        store(32'h300, 32'h33000000, 4'b1000);
        @(negedge clk);
        chk("merge_count", 32'(count), 32'd2);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("merge_addr", mem_addr, 32'h300);
        chk("merge_we", 32'(mem_we), 32'h9);
        chk("merge_wdata", mem_wdata, 32'h33000022);

        // 5: hazard against pending 0x300/1001
        tick();
        ld_addr = 32'h302;
        ld_mask = 4'b0100;
        @(negedge clk);
        chk("hz_nolane", 32'(ld_hazard), 32'd0);
        tick();
        ld_mask = 4'b1000;
        @(negedge clk);
        chk("hz_hit", 32'(ld_hazard), 32'd1);
        tick();
        ld_addr = 32'h304;
        @(negedge clk);
        chk("hz_word", 32'(ld_hazard), 32'd0);

        // 6: reset mid-drain
        tick();
        ld_addr = '0;
        ld_mask = '0;
        store(32'h400, 32'hA, 4'hF);
        store(32'h500, 32'hB, 4'hF);
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd3);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        tick();
        tick();
        store(32'h600, 32'h66, 4'h1);
        @(negedge clk);
        chk("post_rst_head", mem_addr, 32'h600);

        // No merge into a lone head; zero-mask store dropped
        tick();
        store(32'h600, 32'h6600, 4'h2);
        @(negedge clk);
        chk("nomerge_count", 32'(count), 32'd2);
        tick();
        store(32'h700, 32'h77, 4'h0);
        @(negedge clk);
        chk("zmask_count", 32'(count), 32'd2);
        tick();
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        chk("final_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
